// File: rtl/m_axi_master_ctrl.sv
// m_axi_master_ctrl: single-outstanding AXI initiator.
// Converts a cmd/rsp request stream into single-beat AXI writes (AW+W->B)
// and reads (AR->R). Only one transaction is in flight at any time.
//
// Optional feature macro: AXI_TIMEOUT_EN
//   defined   : watchdog aborts a stalled transaction after TIMEOUT_CYC cycles
//               and returns rsp_resp=2'b10.
//   undefined : no watchdog; every handshake is waited for indefinitely.
//
// Ports:
//   clk, areset            clock (rising edge), async active-low reset
//   cmd_*                  request stream (valid/ready, write, id, addr, wdata, wstrb)
//   rsp_*                  response stream (valid/ready, write, id, rdata, resp)
//   aw*/w*/b*              AXI write address / data / response channels
//   ar*/r*                 AXI read address / data channels
module m_axi_master_ctrl #(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned ID_W        = 4,
    parameter int unsigned TIMEOUT_CYC = 256
) (
    input  logic                clk,
    input  logic                areset,
    // request stream
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_write,
    input  logic [ID_W-1:0]     cmd_id,
    input  logic [ADDR_W-1:0]   cmd_addr,
    input  logic [DATA_W-1:0]   cmd_wdata,
    input  logic [DATA_W/8-1:0] cmd_wstrb,
    // response stream
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic                rsp_write,
    output logic [ID_W-1:0]     rsp_id,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic [1:0]          rsp_resp,
    // write address channel
    output logic [ID_W-1:0]     awid_o,
    output logic [ADDR_W-1:0]   awaddr_o,
    output logic                awvalid_o,
    input  logic                awready_i,
    // write data channel
    output logic [ID_W-1:0]     wid_o,
    output logic [DATA_W-1:0]   wdata_o,
    output logic [DATA_W/8-1:0] wstrb_o,
    output logic                wlast_o,
    output logic                wvalid_o,
    input  logic                wready_i,
    // write response channel
    input  logic [ID_W-1:0]     bid_i,
    input  logic [1:0]          bresp_i,
    input  logic                bvalid_i,
    output logic                bready_o,
    // read address channel
    output logic [ID_W-1:0]     arid_o,
    output logic [ADDR_W-1:0]   araddr_o,
    output logic                arvalid_o,
    input  logic                arready_i,
    // read data channel
    input  logic [ID_W-1:0]     rid_i,
    input  logic [DATA_W-1:0]   rdata_i,
    input  logic                rlast_i,
    input  logic                rvalid_i,
    output logic                rready_o
);

    localparam int unsigned STRB_W = DATA_W / 8;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WR_REQ  = 3'd1,
        S_RD_REQ  = 3'd2,
        S_WR_RESP = 3'd3,
        S_RD_DATA = 3'd4,
        S_RSP     = 3'd5
    } state_t;

    state_t state;
    logic   busy;
    logic   tmo_hit;
    logic   aw_fire;
    logic   w_fire;

    // Single-beat bursts only, so rlast is not needed.
    logic unused_rlast;
    assign unused_rlast = rlast_i;

    assign wlast_o = 1'b1;
    assign busy    = (state == S_WR_REQ) || (state == S_RD_REQ) ||
                     (state == S_WR_RESP) || (state == S_RD_DATA);
    assign aw_fire = awvalid_o && awready_i;
    assign w_fire  = wvalid_o && wready_i;

`ifdef AXI_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);

    logic [CNT_W-1:0] tmo_cnt;

    assign tmo_hit = busy && (tmo_cnt == CNT_W'(TIMEOUT_CYC));

    // Watchdog: counts every cycle spent waiting on the slave.
    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            tmo_cnt <= '0;
        end else if (busy && !tmo_hit) begin
            tmo_cnt <= tmo_cnt + CNT_W'(1);
        end else begin
            tmo_cnt <= '0;
        end
    end
`else
    logic [31:0] unused_timeout_cyc;
    assign unused_timeout_cyc = 32'(TIMEOUT_CYC);
    assign tmo_hit            = 1'b0;
`endif

    // Transaction FSM with registered AXI and response outputs.
    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            state     <= S_IDLE;
            cmd_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_write <= 1'b0;
            rsp_id    <= '0;
            rsp_rdata <= '0;
            rsp_resp  <= 2'b00;
            awid_o    <= '0;
            awaddr_o  <= '0;
            awvalid_o <= 1'b0;
            wid_o     <= '0;
            wdata_o   <= '0;
            wstrb_o   <= '0;
            wvalid_o  <= 1'b0;
            bready_o  <= 1'b0;
            arid_o    <= '0;
            araddr_o  <= '0;
            arvalid_o <= 1'b0;
            rready_o  <= 1'b0;
        end else if (tmo_hit) begin
            // Abandon the stalled transaction; late B/R beats find no ready.
            awvalid_o <= 1'b0;
            wvalid_o  <= 1'b0;
            arvalid_o <= 1'b0;
            bready_o  <= 1'b0;
            rready_o  <= 1'b0;
            rsp_id    <= rsp_write ? awid_o : arid_o;
            rsp_rdata <= '0;
            rsp_resp  <= 2'b10;
            rsp_valid <= 1'b1;
            state     <= S_RSP;
        end else begin
            case (state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        cmd_ready <= 1'b0;
                        rsp_write <= cmd_write;
                        if (cmd_write) begin
                            awid_o    <= cmd_id;
                            awaddr_o  <= cmd_addr;
                            wid_o     <= cmd_id;
                            wdata_o   <= cmd_wdata;
                            wstrb_o   <= STRB_W'(cmd_wstrb);
                            awvalid_o <= 1'b1;
                            wvalid_o  <= 1'b1;
                            state     <= S_WR_REQ;
                        end else begin
                            arid_o    <= cmd_id;
                            araddr_o  <= cmd_addr;
                            arvalid_o <= 1'b1;
                            state     <= S_RD_REQ;
                        end
                    end
                end
                S_WR_REQ: begin
                    // AW and W complete independently, in either order.
                    if (aw_fire) awvalid_o <= 1'b0;
                    if (w_fire)  wvalid_o  <= 1'b0;
                    if ((aw_fire || !awvalid_o) && (w_fire || !wvalid_o)) begin
                        bready_o <= 1'b1;
                        state    <= S_WR_RESP;
                    end
                end
                S_WR_RESP: begin
                    if (bvalid_i) begin
                        bready_o  <= 1'b0;
                        rsp_id    <= bid_i;
                        rsp_resp  <= bresp_i;
                        rsp_rdata <= '0;
                        rsp_valid <= 1'b1;
                        state     <= S_RSP;
                    end
                end
                S_RD_REQ: begin
                    if (arready_i) begin
                        arvalid_o <= 1'b0;
                        rready_o  <= 1'b1;
                        state     <= S_RD_DATA;
                    end
                end
                S_RD_DATA: begin
                    if (rvalid_i) begin
                        rready_o  <= 1'b0;
                        rsp_id    <= rid_i;
                        rsp_rdata <= rdata_i;
                        rsp_resp  <= 2'b00;
                        rsp_valid <= 1'b1;
                        state     <= S_RSP;
                    end
                end
                S_RSP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        state     <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_m_axi_master_ctrl.sv
// Directed self-checking bench for m_axi_master_ctrl.
module tb_m_axi_master_ctrl;

    logic        clk;
    logic        areset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [3:0]  cmd_id;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic [3:0]  cmd_wstrb;
    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_write;
    logic [3:0]  rsp_id;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic [3:0]  awid_o;
    logic [31:0] awaddr_o;
    logic        awvalid_o;
    logic        awready_i;
    logic [3:0]  wid_o;
    logic [31:0] wdata_o;
    logic [3:0]  wstrb_o;
    logic        wlast_o;
    logic        wvalid_o;
    logic        wready_i;
    logic [3:0]  bid_i;
    logic [1:0]  bresp_i;
    logic        bvalid_i;
    logic        bready_o;
    logic [3:0]  arid_o;
    logic [31:0] araddr_o;
    logic        arvalid_o;
    logic        arready_i;
    logic [3:0]  rid_i;
    logic [31:0] rdata_i;
    logic        rlast_i;
    logic        rvalid_i;
    logic        rready_o;

    int checks;
    int failures;

    m_axi_master_ctrl #(
        .ADDR_W      (32),
        .DATA_W      (32),
        .ID_W        (4),
        .TIMEOUT_CYC (16)
    ) dut (
        .clk       (clk),
        .areset    (areset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_id    (cmd_id),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .cmd_wstrb (cmd_wstrb),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_write (rsp_write),
        .rsp_id    (rsp_id),
        .rsp_rdata (rsp_rdata),
        .rsp_resp  (rsp_resp),
        .awid_o    (awid_o),
        .awaddr_o  (awaddr_o),
        .awvalid_o (awvalid_o),
        .awready_i (awready_i),
        .wid_o     (wid_o),
        .wdata_o   (wdata_o),
        .wstrb_o   (wstrb_o),
        .wlast_o   (wlast_o),
        .wvalid_o  (wvalid_o),
        .wready_i  (wready_i),
        .bid_i     (bid_i),
        .bresp_i   (bresp_i),
        .bvalid_i  (bvalid_i),
        .bready_o  (bready_o),
        .arid_o    (arid_o),
        .araddr_o  (araddr_o),
        .arvalid_o (arvalid_o),
        .arready_i (arready_i),
        .rid_i     (rid_i),
        .rdata_i   (rdata_i),
        .rlast_i   (rlast_i),
        .rvalid_i  (rvalid_i),
        .rready_o  (rready_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Advance past the next rising edge so outputs have settled.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input logic wr, input logic [3:0] id, input logic [31:0] addr,
                            input logic [31:0] data, input logic [3:0] strb);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_id    = id;
        cmd_addr  = addr;
        cmd_wdata = data;
        cmd_wstrb = strb;
    endtask

    // Write against an always-ready slave; checks the zero-wait timeline.
    task automatic do_write(input string tag, input logic [3:0] id, input logic [31:0] addr,
                            input logic [31:0] data, input logic [3:0] strb);
        awready_i = 1'b1;
        wready_i  = 1'b1;
        bvalid_i  = 1'b1;
        bid_i     = id;
        bresp_i   = 2'b00;
        chk({tag, "_cmd_ready_idle"}, 32'(cmd_ready), 1);
        send_cmd(1'b1, id, addr, data, strb);
        tick();
        cmd_valid = 1'b0;
        chk({tag, "_awvalid_t1"}, 32'(awvalid_o), 1);
        chk({tag, "_wvalid_t1"}, 32'(wvalid_o), 1);
        chk({tag, "_awaddr"}, awaddr_o, addr);
        chk({tag, "_awid"}, 32'(awid_o), 32'(id));
        chk({tag, "_wid"}, 32'(wid_o), 32'(id));
        chk({tag, "_wdata"}, wdata_o, data);
        chk({tag, "_wstrb"}, 32'(wstrb_o), 32'(strb));
        chk({tag, "_bready_t1"}, 32'(bready_o), 0);
        chk({tag, "_cmd_ready_busy"}, 32'(cmd_ready), 0);
        tick();
        chk({tag, "_awvalid_t2"}, 32'(awvalid_o), 0);
        chk({tag, "_wvalid_t2"}, 32'(wvalid_o), 0);
        chk({tag, "_bready_t2"}, 32'(bready_o), 1);
        chk({tag, "_rsp_valid_t2"}, 32'(rsp_valid), 0);
        tick();
        chk({tag, "_rsp_valid_t3"}, 32'(rsp_valid), 1);
        chk({tag, "_rsp_write"}, 32'(rsp_write), 1);
        chk({tag, "_rsp_id"}, 32'(rsp_id), 32'(id));
        chk({tag, "_rsp_resp"}, 32'(rsp_resp), 0);
        chk({tag, "_rsp_rdata"}, rsp_rdata, 0);
        chk({tag, "_bready_t3"}, 32'(bready_o), 0);
        bvalid_i  = 1'b0;
        awready_i = 1'b0;
        wready_i  = 1'b0;
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk({tag, "_rsp_valid_done"}, 32'(rsp_valid), 0);
        chk({tag, "_cmd_ready_done"}, 32'(cmd_ready), 1);
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        areset    = 1'b0;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_id    = '0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        cmd_wstrb = '0;
        rsp_ready = 1'b0;
        awready_i = 1'b0;
        wready_i  = 1'b0;
        bid_i     = '0;
        bresp_i   = 2'b00;
        bvalid_i  = 1'b0;
        arready_i = 1'b0;
        rid_i     = '0;
        rdata_i   = '0;
        rlast_i   = 1'b0;
        rvalid_i  = 1'b0;

        // Reset values
        #12;
        chk("rst_cmd_ready", 32'(cmd_ready), 1);
        chk("rst_rsp_valid", 32'(rsp_valid), 0);
        chk("rst_awvalid", 32'(awvalid_o), 0);
        chk("rst_wvalid", 32'(wvalid_o), 0);
        chk("rst_arvalid", 32'(arvalid_o), 0);
        chk("rst_bready", 32'(bready_o), 0);
        chk("rst_rready", 32'(rready_o), 0);
        chk("rst_wlast", 32'(wlast_o), 1);
        chk("rst_awaddr", awaddr_o, 0);
        chk("rst_rsp_rdata", rsp_rdata, 0);
        areset = 1'b1;
        tick();

        // 1: zero-wait write
        do_write("t1", 4'd3, 32'd2, 32'hDEADBEEF, 4'hF);

        // 2: read with arready delayed 3 cycles; early rvalid must be ignored
        rvalid_i = 1'b1;
        rid_i    = 4'd5;
        rdata_i  = 32'hDEADBEEF;
        send_cmd(1'b0, 4'd5, 32'd2, 32'h0, 4'h0);
        tick();
        cmd_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("t2_arvalid_held", 32'(arvalid_o), 1);
            chk("t2_araddr", araddr_o, 2);
            chk("t2_arid", 32'(arid_o), 5);
            chk("t2_rready_early", 32'(rready_o), 0);
            if (i == 3) arready_i = 1'b1;
            tick();
        end
        arready_i = 1'b0;
        chk("t2_arvalid_drop", 32'(arvalid_o), 0);
        chk("t2_rready", 32'(rready_o), 1);
        tick();
        rvalid_i = 1'b0;
        chk("t2_rsp_valid", 32'(rsp_valid), 1);
        chk("t2_rsp_write", 32'(rsp_write), 0);
        chk("t2_rsp_id", 32'(rsp_id), 5);
        chk("t2_rsp_rdata", rsp_rdata, 32'hDEADBEEF);
        chk("t2_rsp_resp", 32'(rsp_resp), 0);
        chk("t2_rready_drop", 32'(rready_o), 0);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;

        // 3: W accepted two cycles before AW; bresp passed through
        wready_i = 1'b1;
        send_cmd(1'b1, 4'd6, 32'd4, 32'h12345678, 4'h3);
        tick();
        cmd_valid = 1'b0;
        chk("t3_awvalid_t1", 32'(awvalid_o), 1);
        chk("t3_wvalid_t1", 32'(wvalid_o), 1);
        tick();
        wready_i = 1'b0;
        chk("t3_wvalid_drop", 32'(wvalid_o), 0);
        chk("t3_awvalid_held", 32'(awvalid_o), 1);
        chk("t3_bready_early", 32'(bready_o), 0);
        tick();
        chk("t3_awvalid_held2", 32'(awvalid_o), 1);
        chk("t3_awaddr_stable", awaddr_o, 4);
        chk("t3_bready_early2", 32'(bready_o), 0);
        awready_i = 1'b1;
        tick();
        awready_i = 1'b0;
        chk("t3_awvalid_drop", 32'(awvalid_o), 0);
        chk("t3_bready", 32'(bready_o), 1);
        chk("t3_rsp_valid_early", 32'(rsp_valid), 0);
        bvalid_i = 1'b1;
        bid_i    = 4'd6;
        bresp_i  = 2'b10;
        tick();
        bvalid_i = 1'b0;
        chk("t3_rsp_valid", 32'(rsp_valid), 1);
        chk("t3_rsp_resp", 32'(rsp_resp), 2);
        chk("t3_rsp_id", 32'(rsp_id), 6);
        chk("t3_bready_drop", 32'(bready_o), 0);

        // 4: response back-pressure; pending cmd waits for the rsp handshake
        send_cmd(1'b0, 4'd7, 32'd1, 32'h0, 4'h0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t4_rsp_valid_hold", 32'(rsp_valid), 1);
            chk("t4_rsp_resp_hold", 32'(rsp_resp), 2);
            chk("t4_rsp_id_hold", 32'(rsp_id), 6);
            chk("t4_cmd_ready_low", 32'(cmd_ready), 0);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("t4_rsp_valid_drop", 32'(rsp_valid), 0);
        chk("t4_cmd_ready_back", 32'(cmd_ready), 1);
        chk("t4_not_yet_accepted", 32'(arvalid_o), 0);
        tick();
        cmd_valid = 1'b0;
        chk("t4_accepted", 32'(arvalid_o), 1);
        chk("t4_araddr", araddr_o, 1);

        // 5: async reset while waiting in RD_DATA
        arready_i = 1'b1;
        tick();
        arready_i = 1'b0;
        chk("t5_in_rd_data", 32'(rready_o), 1);
        #2;
        areset = 1'b0;
        #1;
        chk("t5_rready_rst", 32'(rready_o), 0);
        chk("t5_cmd_ready_rst", 32'(cmd_ready), 1);
        chk("t5_arvalid_rst", 32'(arvalid_o), 0);
        chk("t5_araddr_rst", araddr_o, 0);
        chk("t5_rsp_valid_rst", 32'(rsp_valid), 0);
        #1;
        areset = 1'b1;
        tick();
        do_write("t5w", 4'd2, 32'd7, 32'hA5A55A5A, 4'h5);

`ifdef AXI_TIMEOUT_EN
        // 6: read whose data never arrives
        begin
            int n;
            arready_i = 1'b1;
            send_cmd(1'b0, 4'd9, 32'd3, 32'h0, 4'h0);
            tick();
            cmd_valid = 1'b0;
            chk("t6_arvalid", 32'(arvalid_o), 1);
            n = 0;
            while (!rsp_valid && n < 40) begin
                tick();
                arready_i = 1'b0;
                n++;
            end
            chk("t6_latency", 32'(n), 17);
            chk("t6_rsp_resp", 32'(rsp_resp), 2);
            chk("t6_rsp_rdata", rsp_rdata, 0);
            chk("t6_rsp_id", 32'(rsp_id), 9);
            chk("t6_rready_drop", 32'(rready_o), 0);
            rvalid_i = 1'b1;
            rid_i    = 4'd9;
            rdata_i  = 32'h11111111;
            tick();
            chk("t6_late_r_ignored", 32'(rready_o), 0);
            chk("t6_rsp_rdata_stable", rsp_rdata, 0);
            rsp_ready = 1'b1;
            tick();
            rsp_ready = 1'b0;
            chk("t6_idle_r_ignored", 32'(rready_o), 0);
            rvalid_i = 1'b0;
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #200000;
        failures++;
        $display("FAIL watchdog got=timeout exp=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
